// File: rtl/prf_pkg.sv
// Shared types and sizing for the physical register file writeback path.
package prf_pkg;

    localparam int XLEN = 64;
    localparam int PHYS = 64;
    localparam int PW   = $clog2(PHYS);
    localparam int NREQ = 3;
    localparam int NQ   = 2;
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [PW-1:0]   preg_t;
    typedef logic [XLEN-1:0] xdata_t;
    typedef logic [PTRW-1:0] rr_ptr_t;

endpackage

// File: rtl/prf_wb_sched_rr_arb.sv
// Round-robin arbiter: picks the first valid requester at or above ptr,
// wrapping modulo N. Produces a one-hot grant and the granted index.
module rr_arb #(
    parameter int N    = 3,
    parameter int PTRW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    valid_i,
    input  logic [PTRW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [PTRW-1:0] idx_o,
    output logic            any_o
);

    // Walk the rotated priority order; the first hit wins.
    always_comb begin
        int cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int i = 0; i < N; i++) begin
                if (!any_o && (cand == i) && valid_i[i]) begin
                    any_o    = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = PTRW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/prf_wb_sched.sv
// Writeback scheduler: round-robin onto the single PRF write port, a
// one-cycle registered output stage, and a per-preg ready scoreboard.
// Optional macro PRF_WB_BYPASS_EN: ready queries also see the write that is
// on the PRF port this cycle, so wakeup arrives one cycle earlier.
module prf_wb_sched
    import prf_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0][PW-1:0]   req_preg,
    input  logic [NREQ-1:0][XLEN-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      prf_we,
    output logic [PW-1:0]             prf_waddr,
    output logic [XLEN-1:0]           prf_wdata,
    input  logic                      alloc_valid,
    input  logic [PW-1:0]             alloc_preg,
    input  logic [NQ-1:0][PW-1:0]     q_preg,
    output logic [NQ-1:0]             q_rdy,
    output logic                      err_dbl_wr
);

    rr_ptr_t         ptr_q, ptr_d;
    logic [NREQ-1:0] gnt;
    rr_ptr_t         gnt_idx;
    logic            gnt_any;
    logic            hs;
    preg_t           sel_preg;
    xdata_t          sel_data;

    logic            we_q;
    preg_t           waddr_q;
    xdata_t          wdata_q;
    logic [PHYS-1:0] rdy_q, rdy_d;
    logic            err_q, err_d;

    rr_arb #(.N(NREQ), .PTRW(PTRW)) u_arb (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // Grants are withheld during reset so nothing is consumed then.
    always_comb begin
        req_ready = rst ? '0 : gnt;
        hs        = gnt_any && !rst;
        ptr_d     = ptr_q;
        if (hs) begin
            ptr_d = (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + PTRW'(1);
        end
    end

    // One-hot select of the granted requester's preg and data.
    always_comb begin
        sel_preg = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_preg = sel_preg | ({PW{gnt[i]}} & req_preg[i]);
            sel_data = sel_data | ({XLEN{gnt[i]}} & req_data[i]);
        end
    end

    // Scoreboard next state; an allocation overrides a same-preg writeback.
    always_comb begin
        rdy_d = rdy_q;
        if (we_q) begin
            rdy_d[waddr_q] = 1'b1;
        end
        if (alloc_valid) begin
            rdy_d[alloc_preg] = 1'b0;
        end
        err_d = err_q || (we_q && rdy_q[waddr_q]);
    end

    // Pointer, output stage, scoreboard and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdy_q   <= '1;
            err_q   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            we_q  <= hs;
            if (hs) begin
                waddr_q <= sel_preg;
                wdata_q <= sel_data;
            end
            rdy_q <= rdy_d;
            err_q <= err_d;
        end
    end

    // Ready lookup per query port, optionally bypassing the in-flight write.
    always_comb begin
        q_rdy = '0;
        for (int k = 0; k < NQ; k++) begin
            q_rdy[k] = rdy_q[q_preg[k]];
`ifdef PRF_WB_BYPASS_EN
            if (we_q && (waddr_q == q_preg[k]) &&
                !(alloc_valid && (alloc_preg == q_preg[k]))) begin
                q_rdy[k] = 1'b1;
            end
`endif
        end
    end

    assign prf_we     = we_q;
    assign prf_waddr  = waddr_q;
    assign prf_wdata  = wdata_q;
    assign err_dbl_wr = err_q;

endmodule
